// File: rtl/sw_arbiter.sv
// Round-robin packet arbiter: N_REQ requesters share one write port, with a
// stall watchdog that revokes a grant whose owner stops making progress.
module sw_arbiter #(
  parameter int unsigned W_WIDTH = 8,
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned TMO     = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ-1:0]           req_last,
  input  logic [N_REQ*W_WIDTH-1:0]   req_data,
  input  logic                       port_busy,
  output logic [N_REQ-1:0]           gnt,
  output logic [N_REQ-1:0]           ack,
  output logic                       wr_en,
  output logic [W_WIDTH-1:0]         data_out,
  output logic                       wdog
);

  localparam int unsigned IDX_W = $clog2(N_REQ);
  localparam int unsigned CNT_W = $clog2(TMO);

  typedef enum logic {IDLE, XFER} state_t;

  state_t             state_q, state_n;
  logic [IDX_W-1:0]   gnt_idx_q, gnt_idx_n;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_n;
  logic [CNT_W-1:0]   stall_q, stall_n;
  logic [N_REQ-1:0]   gnt_n;
  logic               wr_en_n;
  logic [W_WIDTH-1:0] data_n;
  logic               wdog_n;

  logic               accept;
  logic               sel_found;
  logic [IDX_W-1:0]   sel_idx;
  logic [IDX_W-1:0]   ptr_inc;
  logic [W_WIDTH-1:0] data_arr [N_REQ];

  // Beat handshake is purely combinational so the requester can advance same cycle.
  assign accept  = (state_q == XFER) && req[gnt_idx_q] && !port_busy && !rst;
  assign ack     = {N_REQ{accept}} & gnt;
  assign ptr_inc = (gnt_idx_q == IDX_W'(N_REQ - 1)) ? '0 : gnt_idx_q + IDX_W'(1);

  always_comb begin
    for (int i = 0; i < int'(N_REQ); i++) begin
      data_arr[i] = req_data[i*W_WIDTH +: W_WIDTH];
    end
  end

  // Circular search for the first requester at or after rr_ptr.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      int cand;
      cand = int'(rr_ptr_q) + i;
      if (cand >= int'(N_REQ)) cand = cand - int'(N_REQ);
      if (!sel_found && req[cand]) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(cand);
      end
    end
  end

  always_comb begin
    state_n   = state_q;
    gnt_n     = gnt;
    gnt_idx_n = gnt_idx_q;
    rr_ptr_n  = rr_ptr_q;
    stall_n   = stall_q;
    wr_en_n   = 1'b0;
    data_n    = data_out;
    wdog_n    = 1'b0;
    case (state_q)
      IDLE: begin
        if (sel_found) begin
          gnt_n     = N_REQ'(1) << sel_idx;
          gnt_idx_n = sel_idx;
          stall_n   = '0;
          state_n   = XFER;
        end
      end
      XFER: begin
        if (accept) begin
          wr_en_n = 1'b1;
          data_n  = data_arr[gnt_idx_q];
          stall_n = '0;
          if (req_last[gnt_idx_q]) begin
            gnt_n    = '0;
            rr_ptr_n = ptr_inc;
            state_n  = IDLE;
          end
        end else if (stall_q == CNT_W'(TMO - 1)) begin
          // Owner made no progress for TMO cycles: revoke and move on.
          wdog_n   = 1'b1;
          gnt_n    = '0;
          rr_ptr_n = ptr_inc;
          state_n  = IDLE;
        end else begin
          stall_n = stall_q + CNT_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      gnt       <= '0;
      gnt_idx_q <= '0;
      rr_ptr_q  <= '0;
      stall_q   <= '0;
      wr_en     <= 1'b0;
      data_out  <= '0;
      wdog      <= 1'b0;
    end else begin
      state_q   <= state_n;
      gnt       <= gnt_n;
      gnt_idx_q <= gnt_idx_n;
      rr_ptr_q  <= rr_ptr_n;
      stall_q   <= stall_n;
      wr_en     <= wr_en_n;
      data_out  <= data_n;
      wdog      <= wdog_n;
    end
  end

endmodule

// File: tb/tb_sw_arbiter.sv
// Directed bench for sw_arbiter; written beats are matched against a queue of
// expected words filled as each accepted beat is driven.
module tb_sw_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = '0;
  logic [3:0]  req_last = '0;
  logic [31:0] req_data = '0;
  logic        port_busy = 1'b0;
  logic [3:0]  gnt;
  logic [3:0]  ack;
  logic        wr_en;
  logic [7:0]  data_out;
  logic        wdog;

  int checks = 0;
  int errors = 0;
  logic [7:0] sb_q [$];

  sw_arbiter #(.W_WIDTH(8), .N_REQ(4), .TMO(16)) dut (
    .clk(clk), .rst(rst), .req(req), .req_last(req_last), .req_data(req_data),
    .port_busy(port_busy), .gnt(gnt), .ack(ack), .wr_en(wr_en),
    .data_out(data_out), .wdog(wdog)
  );

  always #5 clk = ~clk;

  // Every write on the shared port must match the oldest expected beat.
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got write %0h expected no write", data_out);
      end else begin
        logic [7:0] exp_d;
        exp_d = sb_q.pop_front();
        if (data_out !== exp_d) begin
          errors++;
          $display("FAIL sb_data: got %0h expected %0h", data_out, exp_d);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int i, input logic v, input logic l, input logic [7:0] d);
    req[i] = v;
    req_last[i] = l;
    req_data[i*8 +: 8] = d;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL rst_gnt: got %b expected 0000", gnt); end
    checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL rst_wr_en: got %b expected 0", wr_en); end
    checks++; if (wdog !== 1'b0) begin errors++; $display("FAIL rst_wdog: got %b expected 0", wdog); end
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL rst_data: got %0h expected 0", data_out); end
    req = 4'b1111;
    #1;
    checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL rst_ack: got %b expected 0000", ack); end
    tick();
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL rst_gnt_held: got %b expected 0000", gnt); end
    req = 4'b0000;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    drive(0, 1'b1, 1'b0, 8'hA1);
    drive(2, 1'b1, 1'b1, 8'hC0);
    #1;
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL basic_sel_gnt: got %b expected 0000", gnt); end
    checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL basic_sel_ack: got %b expected 0000", ack); end
    tick();
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL basic_gnt0: got %b expected 0001", gnt); end
    checks++; if (ack !== 4'b0001) begin errors++; $display("FAIL basic_ack0: got %b expected 0001", ack); end
    sb_q.push_back(8'hA1);
    tick();
    drive(0, 1'b1, 1'b0, 8'hA2);
    sb_q.push_back(8'hA2);
    tick();
    drive(0, 1'b1, 1'b1, 8'hA3);
    sb_q.push_back(8'hA3);
    #1;
    checks++; if (ack !== 4'b0001) begin errors++; $display("FAIL basic_ack_last: got %b expected 0001", ack); end
    tick();
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL basic_release: got %b expected 0000", gnt); end
    checks++; if (wr_en !== 1'b1) begin errors++; $display("FAIL basic_wr3: got %b expected 1", wr_en); end
    drive(0, 1'b0, 1'b0, 8'h00);
    tick();
    checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL basic_gnt2: got %b expected 0100", gnt); end
    checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL basic_idle_wr: got %b expected 0", wr_en); end
    sb_q.push_back(8'hC0);
    tick();
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL basic_release2: got %b expected 0000", gnt); end
    drive(2, 1'b0, 1'b0, 8'h00);
    tick();
    checks++; if (wr_en !== 1'b0 || data_out !== 8'hC0) begin
      errors++; $display("FAIL basic_hold: got wr_en=%b data=%0h expected wr_en=0 data=c0", wr_en, data_out);
    end
  endtask

  task automatic test_round_robin();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) drive(i, 1'b1, 1'b1, 8'h50 + 8'(i));
    for (int k = 0; k < 5; k++) begin
      logic [3:0] exp_g;
      exp_g = 4'b0001 << (k % 4);
      tick();
      checks++; if (gnt !== exp_g) begin errors++; $display("FAIL rr_gnt%0d: got %b expected %b", k, gnt, exp_g); end
      checks++; if (ack !== exp_g) begin errors++; $display("FAIL rr_ack%0d: got %b expected %b", k, ack, exp_g); end
      sb_q.push_back(8'h50 + 8'(k % 4));
      tick();
      checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL rr_gap%0d: got %b expected 0000", k, gnt); end
    end
    req = 4'b0000;
    req_last = 4'b0000;
    tick();
  endtask

  task automatic test_busy();
    drive(1, 1'b1, 1'b1, 8'h77);
    port_busy = 1'b1;
    tick();
    checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL busy_gnt: got %b expected 0010", gnt); end
    for (int b = 0; b < 5; b++) begin
      checks++; if (ack !== 4'b0000 || wr_en !== 1'b0) begin
        errors++; $display("FAIL busy_hold%0d: got ack=%b wr_en=%b expected ack=0000 wr_en=0", b, ack, wr_en);
      end
      tick();
    end
    checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL busy_gnt_kept: got %b expected 0010", gnt); end
    port_busy = 1'b0;
    sb_q.push_back(8'h77);
    #1;
    checks++; if (ack !== 4'b0010) begin errors++; $display("FAIL busy_ack: got %b expected 0010", ack); end
    tick();
    checks++; if (wr_en !== 1'b1) begin errors++; $display("FAIL busy_write: got %b expected 1", wr_en); end
    drive(1, 1'b0, 1'b0, 8'h00);
    tick();
    checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL busy_once: got %b expected 0", wr_en); end
  endtask

  task automatic test_timeout();
    drive(2, 1'b1, 1'b0, 8'h21);
    drive(3, 1'b1, 1'b1, 8'h31);
    tick();
    checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL tmo_gnt: got %b expected 0100", gnt); end
    sb_q.push_back(8'h21);
    tick();
    drive(2, 1'b0, 1'b0, 8'h00);
    for (int t = 0; t < 16; t++) begin
      checks++; if (wdog !== 1'b0 || gnt !== 4'b0100) begin
        errors++; $display("FAIL tmo_wait%0d: got wdog=%b gnt=%b expected wdog=0 gnt=0100", t, wdog, gnt);
      end
      tick();
    end
    checks++; if (wdog !== 1'b1) begin errors++; $display("FAIL tmo_wdog: got %b expected 1", wdog); end
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL tmo_revoke: got %b expected 0000", gnt); end
    tick();
    checks++; if (wdog !== 1'b0) begin errors++; $display("FAIL tmo_pulse: got %b expected 0", wdog); end
    checks++; if (gnt !== 4'b1000) begin errors++; $display("FAIL tmo_next: got %b expected 1000", gnt); end
    sb_q.push_back(8'h31);
    tick();
    drive(3, 1'b0, 1'b0, 8'h00);
    tick();
  endtask

  task automatic test_timeout_last();
    drive(0, 1'b1, 1'b0, 8'h40);
    tick();
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL tl_gnt: got %b expected 0001", gnt); end
    sb_q.push_back(8'h40);
    tick();
    drive(0, 1'b0, 1'b0, 8'h00);
    for (int t = 0; t < 15; t++) tick();
    drive(0, 1'b1, 1'b1, 8'h41);
    sb_q.push_back(8'h41);
    #1;
    checks++; if (ack !== 4'b0001) begin errors++; $display("FAIL tl_ack: got %b expected 0001", ack); end
    tick();
    checks++; if (wdog !== 1'b0) begin errors++; $display("FAIL tl_wdog: got %b expected 0", wdog); end
    checks++; if (gnt !== 4'b0000 || wr_en !== 1'b1) begin
      errors++; $display("FAIL tl_release: got gnt=%b wr_en=%b expected gnt=0000 wr_en=1", gnt, wr_en);
    end
    drive(0, 1'b0, 1'b0, 8'h00);
    tick();
    checks++; if (wdog !== 1'b0) begin errors++; $display("FAIL tl_wdog_after: got %b expected 0", wdog); end
  endtask

  task automatic test_reset_mid();
    drive(1, 1'b1, 1'b0, 8'h81);
    tick();
    checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL rm_gnt: got %b expected 0010", gnt); end
    sb_q.push_back(8'h81);
    tick();
    drive(1, 1'b1, 1'b0, 8'h82);
    rst = 1'b1;
    #1;
    checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL rm_ack: got %b expected 0000", ack); end
    tick();
    checks++; if (gnt !== 4'b0000 || wr_en !== 1'b0) begin
      errors++; $display("FAIL rm_abort: got gnt=%b wr_en=%b expected gnt=0000 wr_en=0", gnt, wr_en);
    end
    rst = 1'b0;
    drive(0, 1'b1, 1'b1, 8'h01);
    drive(1, 1'b1, 1'b0, 8'h81);
    tick();
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL rm_ptr0: got %b expected 0001", gnt); end
    sb_q.push_back(8'h01);
    tick();
    drive(0, 1'b0, 1'b0, 8'h00);
    tick();
    checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL rm_restart: got %b expected 0010", gnt); end
    for (int b = 0; b < 4; b++) begin
      drive(1, 1'b1, (b == 3), 8'h81 + 8'(b));
      sb_q.push_back(8'h81 + 8'(b));
      tick();
    end
    checks++; if (gnt !== 4'b0000 || wr_en !== 1'b1) begin
      errors++; $display("FAIL rm_done: got gnt=%b wr_en=%b expected gnt=0000 wr_en=1", gnt, wr_en);
    end
    drive(1, 1'b0, 1'b0, 8'h00);
    tick();
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_round_robin();
    test_busy();
    test_timeout();
    test_timeout_last();
    test_reset_mid();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d pending writes expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sw_arbiter.md
SW_ARBITER -- requirements
Module: sw_arbiter

Interface
REQ-001 SHALL have parameter W_WIDTH, default 8, data beat width in bits.
REQ-002 SHALL have parameter N_REQ, default 4, number of requesters (2..8).
REQ-003 SHALL have parameter TMO, default 16, stall cycles before grant revocation (2..255).
REQ-004 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous reset, active-high.
REQ-006 SHALL have port req  input  N_REQ  per-requester beat valid.
REQ-007 SHALL have port req_last  input  N_REQ  per-requester final-beat marker, qualified by req.
REQ-008 SHALL have port req_data  input  N_REQ*W_WIDTH  requester i data in bits [i*W_WIDTH +: W_WIDTH].
REQ-009 SHALL have port port_busy  input  1  shared output port cannot accept a beat this cycle.
REQ-010 SHALL have port gnt  output  N_REQ  registered one-hot grant, all-zero when idle.
REQ-011 SHALL have port ack  output  N_REQ  combinational per-requester beat-accepted strobe.
REQ-012 SHALL have port wr_en  output  1  registered write strobe to shared port.
REQ-013 SHALL have port data_out  output  W_WIDTH  registered data accompanying wr_en.
REQ-014 SHALL have port wdog  output  1  registered one-cycle grant-timeout pulse.

Function
REQ-015 SHALL implement two states: IDLE (gnt=0) and XFER (gnt one-hot).
REQ-016 IDLE: when any req bit is 1, SHALL select the first set bit at or after rr_ptr (circular, index ascending), set gnt to it, and enter XFER at the next edge; no beat is accepted in the selection cycle.
REQ-017 XFER: accept = req[g] & ~port_busy for granted index g; ack[g] SHALL equal accept, and all other ack bits SHALL be 0.
REQ-018 On accept, wr_en SHALL be 1 and data_out SHALL be req_data[g] on the next cycle (latency 1); otherwise wr_en SHALL be 0 and data_out SHALL hold.
REQ-019 On accept with req_last[g]=1: SHALL clear gnt, set rr_ptr=(g+1) mod N_REQ, and return to IDLE at the next edge.
REQ-020 In XFER, req[g]=0 without a prior last SHALL keep the grant (requester gap allowed) and count toward timeout.
REQ-021 Stall counter SHALL reset to 0 on entering XFER and on each accept, and SHALL increment on each XFER cycle without accept.
REQ-022 When the stall counter reaches TMO-1 and the current cycle has no accept: SHALL pulse wdog for one cycle, clear gnt, set rr_ptr=(g+1) mod N_REQ, and enter IDLE.
REQ-023 A last beat accepted in the same cycle that the timeout would fire SHALL take precedence: normal release, no wdog.
REQ-024 Requests from non-granted requesters SHALL be ignored during XFER; arbitration SHALL occur only in IDLE, giving one idle cycle between grants.
REQ-025 port_busy SHALL be sampled only as in REQ-017; a beat presented while busy SHALL NOT be written, and the requester holds it.

Reset
REQ-026 With rst=1 at an edge: state=IDLE, gnt=0, wr_en=0, data_out=0, wdog=0, rr_ptr=0, stall counter=0.
REQ-027 Reset asserted mid-packet SHALL abort the transfer with no wr_en in the following cycle.
REQ-028 ack SHALL be 0 throughout any cycle in which rst=1.

Verification
REQ-029 After reset, req=4'b0101 -> gnt=4'b0001 one cycle later; 3 beats (A1,A2,A3 last) with port_busy=0 -> wr_en high for 3 consecutive cycles with A1..A3; gnt=4'b0100 two cycles after the A3 accept.
REQ-030 All four requesters issue 1-beat packets continuously -> grant order 0,1,2,3,0, each grant lasting 1 cycle with 1 idle cycle between grants.
REQ-031 Grant to requester 1, port_busy=1 for 5 cycles, then 0 -> no wr_en and ack[1]=0 while busy; beat written exactly once after release.
REQ-032 Grant to requester 2, req[2] dropped with TMO=16 -> wdog pulses 16 cycles after the last accept, gnt=0, next grant goes to requester 3 if requesting.
REQ-033 rst=1 during beat 2 of a 4-beat packet -> next cycle gnt=0, wr_en=0, rr_ptr=0; packet restarts cleanly after rst deasserts.
REQ-034 Last beat accepted on the exact timeout cycle -> normal release, wdog stays 0.
